// File: rtl/mult_result_fifo.sv
// Four-entry first-word-fall-through FIFO that captures one multiplier result
// per rising edge of done_flag and records dropped results in a sticky flag.
module mult_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_flag,
  input  logic [WIDTH-1:0] product,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       level,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  // Pointers are 2 bits wide, so only DEPTH == 4 is meaningful.
  logic [WIDTH-1:0] mem [DEPTH];

  logic       done_q, done_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] level_q, level_d;
  logic       ovf_q, ovf_d;

  logic capture;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    empty     = (level_q == 3'd0);
    full      = (level_q == 3'd4);
    out_valid = !empty;
    out_data  = empty ? '0 : mem[rd_ptr_q];
    level     = level_q;
    overflow  = ovf_q;
  end

  always_comb begin
    capture = done_flag && !done_q;
    pop     = out_valid && out_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    push    = capture && (!full || pop);
    drop    = capture && full && !pop;

    done_d   = done_flag;
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase

    // Setting on a drop takes priority over a concurrent clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q   <= 1'b0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      level_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= product;
    end
  end

endmodule

// File: tb/tb_mult_result_fifo.sv
// Self-checking bench for mult_result_fifo: table-driven vectors plus
// hand-written sequences, with a queue scoreboard checking every pop.
module tb_mult_result_fifo;

  logic        clk;
  logic        rst;
  logic        done_flag;
  logic [15:0] product;
  logic        out_ready;
  logic        clr_ovf;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  level;
  logic        full;
  logic        empty;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic        m_ovf;
  logic        prev_done;

  typedef struct {
    logic        d;
    logic [15:0] p;
    logic        r;
    logic [2:0]  lvl;
    logic        vld;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[6];

  mult_result_fifo #(.WIDTH(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .done_flag (done_flag),
    .product   (product),
    .out_ready (out_ready),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the scoreboard predicts pops, captures and drops.
  task automatic drive(input logic d, input logic [15:0] p, input logic r, input logic c);
    int  sz;
    logic mpop;
    logic rise;
    done_flag = d;
    product   = p;
    out_ready = r;
    clr_ovf   = c;
    #1;
    sz   = exp_q.size();
    mpop = r && (sz > 0);
    rise = d && !prev_done;
    chk("out_valid", {31'd0, out_valid}, {31'd0, sz > 0});
    if (mpop) chk("pop_data", {16'd0, out_data}, {16'd0, exp_q[0]});
    @(posedge clk);
    #1;
    if (mpop) void'(exp_q.pop_front());
    if (rise && (sz < 4 || mpop)) exp_q.push_back(p);
    if (rise && sz == 4 && !mpop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    prev_done = d;
    chk("level", {29'd0, level}, exp_q.size());
    chk("full", {31'd0, full}, {31'd0, exp_q.size() == 4});
    chk("empty", {31'd0, empty}, {31'd0, exp_q.size() == 0});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    $display("cyc d=%0b p=%h r=%0b c=%0b -> lvl=%0d vld=%0b data=%h ovf=%0b",
             d, p, r, c, level, out_valid, out_data, overflow);
  endtask

  task automatic pulse(input logic [15:0] p, input logic r, input logic c);
    drive(1'b1, p, r, c);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf     = 1'b0;
    prev_done = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h00E1, 1'b1, 3'd1, 1'b1, 16'h00E1};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 16'h1234, 1'b0, 3'd1, 1'b1, 16'h1234};
    vecs[3] = '{1'b1, 16'h1234, 1'b0, 3'd1, 1'b1, 16'h1234};
    vecs[4] = '{1'b1, 16'h1234, 1'b0, 3'd1, 1'b1, 16'h1234};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h0000};

    rst       = 1'b0;
    done_flag = 1'b0;
    product   = 16'h0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    model_reset();
    #3;
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single result and held done_flag
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].d, vecs[i].p, vecs[i].r, 1'b0);
      chk("vec_level", {29'd0, level}, {29'd0, vecs[i].lvl});
      chk("vec_valid", {31'd0, out_valid}, {31'd0, vecs[i].vld});
      chk("vec_data", {16'd0, out_data}, {16'd0, vecs[i].data});
    end

    // Fill and overflow
    for (int i = 1; i <= 5; i++) pulse(i[15:0], 1'b0, 1'b0);
    chk("fill_level", {29'd0, level}, 32'd4);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_ovf", {31'd0, overflow}, 32'd1);
    chk("head_stable", {16'd0, out_data}, 32'd1);

    // Clear without a drop
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);

    // Push and pop at full
    pulse(16'hAAAA, 1'b1, 1'b0);
    chk("pp_level", {29'd0, level}, 32'd4);
    chk("pp_ovf", {31'd0, overflow}, 32'd0);

    // Drop, then a clear that coincides with another drop
    pulse(16'hBBBB, 1'b0, 1'b0);
    chk("drop_ovf", {31'd0, overflow}, 32'd1);
    pulse(16'hCCCC, 1'b0, 1'b1);
    chk("set_wins", {31'd0, overflow}, 32'd1);

    // Drain: 2, 3, 4, then AAAA as last entry
    for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("last_entry", {16'd0, out_data}, 32'h0000AAAA);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("drained", {31'd0, empty}, 32'd1);
    drive(1'b0, 16'h0, 1'b0, 1'b1);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) pulse(16'h7000 + i[15:0], 1'b0, 1'b0);
    chk("pre_rst_level", {29'd0, level}, 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_level", {29'd0, level}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", {16'd0, out_data}, 32'd0);
    #1 rst = 1'b1;
    model_reset();
    pulse(16'h0F0F, 1'b0, 1'b0);
    chk("post_rst_data", {16'd0, out_data}, 32'h00000F0F);
    drive(1'b0, 16'h0, 1'b1, 1'b0);

    // done_flag already high at reset release counts as a rising edge
    #2 rst = 1'b0;
    done_flag = 1'b1;
    product   = 16'h5A5A;
    #2 rst = 1'b1;
    model_reset();
    drive(1'b1, 16'h5A5A, 1'b0, 1'b0);
    chk("rel_capture", {29'd0, level}, 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
